periph_bus_decoder: RTL

//  Parametrised address decoder plus response mux between the CPU data port and N_SLV memory-mapped slaves
//  (dmem, tbman, gpio, ...). Regions are defined by BASE/MASK pairs instead of hard-coded compares.

---
 rtl/periph_bus_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/periph_bus_decoder.sv
`default_nettype none
// ============================================================================
// periph_bus_decoder : BASE/MASK region decoder, per-access FSM, response mux
// Revision 1.0
// ============================================================================
module periph_bus_decoder #(
   parameter int                   N_SLV   = 4,
   parameter int                   AW      = 32,
   parameter int                   DW      = 32,
   parameter logic [N_SLV*AW-1:0]  BASE    = {32'h1000_0000, 32'h3000_0000,
                                              32'h8000_F000, 32'h8000_2000},
   parameter logic [N_SLV*AW-1:0]  MASK    = {32'hF000_0000, 32'hF000_0000,
                                              32'hFFFF_F000, 32'hFFFF_F000},
   parameter int                   TIMEOUT = 15
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                m_req_i,
   input  logic                m_we_i,
   input  logic [AW-1:0]       m_addr_i,
   output logic [DW-1:0]       m_rdata_o,
   output logic                m_ready_o,
   output logic                m_err_o,
   output logic [AW-1:0]       err_addr_o,
   output logic [N_SLV-1:0]    s_cs_n_o,
   input  logic [N_SLV*DW-1:0] s_rdata_i,
   input  logic [N_SLV-1:0]    s_ready_i
);

   localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [AW-1:0]     err_addr_q, err_addr_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [N_SLV-1:0]  cs_n_q, cs_n_d;

   logic [N_SLV-1:0]  hit_vec;
   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic              sel_ready;
   logic [DW-1:0]     sel_rdata;

   // Write strobe is routed to slaves outside this block.
   logic              unused_we;
   assign unused_we = m_we_i;

   for (genvar g = 0; g < N_SLV; g++) begin : g_region
      assign hit_vec[g] = ((m_addr_i & MASK[g*AW +: AW]) ==
                           (BASE[g*AW +: AW] & MASK[g*AW +: AW]));
   end

   // Scan downwards so the lowest matching region is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign sel_ready = s_ready_i[idx_q];
   assign sel_rdata = s_rdata_i[idx_q*DW +: DW];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_addr_d = err_addr_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      cs_n_d     = '1;

      case (state_q)
         IDLE: begin
            if (m_req_i) begin
               if (hit) begin
                  state_d = WAIT;
                  idx_d   = hit_idx;
                  cnt_d   = '0;
               end else begin
                  state_d    = ERR;
                  rdata_d    = '0;
                  err_addr_d = m_addr_i;
               end
            end
         end
         WAIT: begin
            if (sel_ready) begin
               state_d = RESP;
               rdata_d = sel_rdata;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CNT_LAST) begin
                  state_d    = ERR;
                  rdata_d    = '0;
                  err_addr_d = m_addr_i;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the state being entered.
      ready_d = (state_d == RESP) || (state_d == ERR);
      err_d   = (state_d == ERR);
      if (state_d == WAIT) begin
         cs_n_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_addr_q <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_addr_q <= err_addr_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign m_rdata_o  = rdata_q;
   assign m_ready_o  = ready_q;
   assign m_err_o    = err_q;
   assign err_addr_o = err_addr_q;
   assign s_cs_n_o   = cs_n_q;

endmodule
`default_nettype wire
